// File: rtl/operm_pkg.sv
// -----------------------------------------------------------------------------
// operm_pkg
// Shared definitions for the output-permutation kernel-parameter sequencer.
// It provides:
//   - the default widths and depth used by operm_kp_seq and operm_kp_tbl
//   - the sequencer state encoding (IDLE / FETCH / ISSUE)
//   - the program table entry layout {ctrl, rep}
// -----------------------------------------------------------------------------
package operm_pkg;

    localparam int SELW_DEF  = 3;
    localparam int REPW_DEF  = 8;
    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    // One program step: the select word and how many times it is issued.
    typedef struct packed {
        logic [SELW_DEF-1:0] ctrl;
        logic [REPW_DEF-1:0] rep;
    } kp_entry_t;

endpackage

// File: rtl/operm_kp_tbl.sv
// -----------------------------------------------------------------------------
// operm_kp_tbl
// Program table for the kernel-parameter sequencer. It is a DEPTH x (SELW+REPW)
// register file with one synchronous write port and one asynchronous read port.
// The contents are deliberately not reset.
// Ports:
//   clk               clock
//   we, waddr         write strobe and write address
//   wctrl, wrep       select word and repeat count to store
//   raddr             read address (combinational read)
//   rctrl, rrep       entry at raddr
// -----------------------------------------------------------------------------
module operm_kp_tbl
    import operm_pkg::*;
#(
    parameter int SELW  = SELW_DEF,
    parameter int REPW  = REPW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SELW-1:0] wctrl,
    input  logic [REPW-1:0] wrep,
    input  logic [AW-1:0]   raddr,
    output logic [SELW-1:0] rctrl,
    output logic [REPW-1:0] rrep
);

    logic [SELW-1:0] ctrl_mem [DEPTH];
    logic [REPW-1:0] rep_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            ctrl_mem[waddr] <= wctrl;
            rep_mem[waddr]  <= wrep;
        end
    end

    assign rctrl = ctrl_mem[raddr];
    assign rrep  = rep_mem[raddr];

endmodule

// File: rtl/operm_kp_seq.sv
// -----------------------------------------------------------------------------
// operm_kp_seq
// Initiator for the kernel-parameter handshake (t_kp_req / t_kp_ack / k_ctrl)
// of the output permutation controller. It plays a programmed list of select
// words, each one a programmed number of times, once or in a loop.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   cfg_we/addr/ctrl/rep table write port (accepted only while idle)
//   cfg_len, cfg_loop   program length (1..DEPTH) and loop flag, taken at start
//   start, stop         begin program / request halt (pulses)
//   t_kp_req, k_ctrl    request and select word (held until accepted)
//   t_kp_ack            responder accept
//   busy, done, err     running flag, end-of-run pulse, illegal-start pulse
// -----------------------------------------------------------------------------
module operm_kp_seq
    import operm_pkg::*;
#(
    parameter int SELW  = SELW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int REPW  = REPW_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [SELW-1:0] cfg_ctrl,
    input  logic [REPW-1:0] cfg_rep,
    input  logic [AW:0]     cfg_len,
    input  logic            cfg_loop,
    input  logic            start,
    input  logic            stop,
    output logic            t_kp_req,
    output logic [SELW-1:0] k_ctrl,
    input  logic            t_kp_ack,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [REPW-1:0] rem;
    logic [AW:0]     len;
    logic            loop;
    logic            stop_pend;

    logic [AW:0]     ptr_inc;
    logic            has_next;
    logic            advance;
    logic [AW-1:0]   nxt_ptr;
    logic [AW-1:0]   rd_addr;
    logic [SELW-1:0] rd_ctrl;
    logic [REPW-1:0] rd_rep;
    logic            xfer;
    logic            stop_now;
    logic            len_ok;
    logic            end_run;

    // ptr+1 is formed one bit wider so that ptr=DEPTH-1 with len=DEPTH
    // compares correctly instead of wrapping to zero.
    assign ptr_inc  = {1'b0, ptr} + (AW+1)'(1);
    assign has_next = (ptr_inc < len);
    assign advance  = has_next | loop;
    assign nxt_ptr  = has_next ? ptr_inc[AW-1:0] : '0;

    // In ISSUE the table looks one entry ahead so the last transfer of a word
    // can load the next word in the same edge without a bubble.
    assign rd_addr  = (state == ST_ISSUE) ? nxt_ptr : ptr;

    assign xfer     = t_kp_req & t_kp_ack;
    // A stop arriving on the same cycle as a transfer already counts.
    assign stop_now = stop_pend | stop;
    assign len_ok   = (cfg_len != '0) && (cfg_len <= DEPTH_W);

    always_comb begin
        end_run = 1'b0;
        case (state)
            ST_FETCH: end_run = stop_now || ((rd_rep == '0) && !advance);
            ST_ISSUE: end_run = xfer && (stop_now || ((rem <= REPW'(1)) && !advance));
            default:  end_run = 1'b0;
        endcase
    end

    operm_kp_tbl #(
        .SELW  (SELW),
        .REPW  (REPW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tbl (
        .clk   (clk),
        .we    (cfg_we && (state == ST_IDLE)),
        .waddr (cfg_addr),
        .wctrl (cfg_ctrl),
        .wrep  (cfg_rep),
        .raddr (rd_addr),
        .rctrl (rd_ctrl),
        .rrep  (rd_rep)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            rem       <= '0;
            len       <= '0;
            loop      <= 1'b0;
            stop_pend <= 1'b0;
            t_kp_req  <= 1'b0;
            k_ctrl    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (end_run) begin
                t_kp_req  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                stop_pend <= 1'b0;
                state     <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (len_ok) begin
                                len       <= cfg_len;
                                loop      <= cfg_loop;
                                ptr       <= '0;
                                rem       <= '0;
                                stop_pend <= 1'b0;
                                busy      <= 1'b1;
                                state     <= ST_FETCH;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (rd_rep != '0) begin
                            rem      <= rd_rep;
                            k_ctrl   <= rd_ctrl;
                            t_kp_req <= 1'b1;
                            state    <= ST_ISSUE;
                        end else begin
                            ptr <= nxt_ptr;
                        end
                    end
                    ST_ISSUE: begin
                        if (xfer) begin
                            if (rem > REPW'(1)) begin
                                rem <= rem - REPW'(1);
                            end else begin
                                ptr <= nxt_ptr;
                                if (rd_rep != '0) begin
                                    rem    <= rd_rep;
                                    k_ctrl <= rd_ctrl;
                                end else begin
                                    t_kp_req <= 1'b0;
                                    state    <= ST_FETCH;
                                end
                            end
                        end else if (stop) begin
                            stop_pend <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operm_kp_seq.sv
// -----------------------------------------------------------------------------
// tb_operm_kp_seq
// Directed bench for operm_kp_seq. Transfers are logged with the cycle index
// relative to the start pulse (index 1 = two cycles after start) and compared
// against hand-computed sequences.
// -----------------------------------------------------------------------------
module tb_operm_kp_seq;
    import operm_pkg::*;

    localparam int SELW  = 3;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int REPW  = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [SELW-1:0] cfg_ctrl;
    logic [REPW-1:0] cfg_rep;
    logic [AW:0]     cfg_len;
    logic            cfg_loop;
    logic            start;
    logic            stop;
    logic            t_kp_req;
    logic [SELW-1:0] k_ctrl;
    logic            t_kp_ack;
    logic            busy;
    logic            done;
    logic            err;

    operm_kp_seq #(
        .SELW  (SELW),
        .DEPTH (DEPTH),
        .AW    (AW),
        .REPW  (REPW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_ctrl (cfg_ctrl),
        .cfg_rep  (cfg_rep),
        .cfg_len  (cfg_len),
        .cfg_loop (cfg_loop),
        .start    (start),
        .stop     (stop),
        .t_kp_req (t_kp_req),
        .k_ctrl   (k_ctrl),
        .t_kp_ack (t_kp_ack),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int r, done_r, hold_bad, ack_mode, cyc;
    int req_r0, busy_r0, busy_done;
    int xq_c[$];
    int xq_r[$];
    int exp_q[$];
    logic            prev_req, prev_xfer, prev_rst;
    logic [SELW-1:0] prev_k;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Log this cycle's transfer, advance one clock, sample #1 after the edge.
    task automatic step();
        logic x;
        x = t_kp_req && t_kp_ack;
        if (x) begin
            xq_c.push_back(int'(k_ctrl));
            xq_r.push_back(r);
        end
        prev_req  = t_kp_req;
        prev_k    = k_ctrl;
        prev_xfer = x;
        prev_rst  = !reset_n;
        @(posedge clk);
        #1;
        cyc++;
        t_kp_ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? cyc[0] : 1'b0;
        if (prev_req && !prev_xfer && !prev_rst && (!t_kp_req || k_ctrl != prev_k))
            hold_bad++;
    endtask

    task automatic wr(input int addr, input int ctrl, input int rep);
        kp_entry_t e;
        e.ctrl   = SELW'(ctrl);
        e.rep    = REPW'(rep);
        cfg_addr = AW'(addr);
        cfg_ctrl = e.ctrl;
        cfg_rep  = e.rep;
        cfg_we   = 1'b1;
        step();
        cfg_we   = 1'b0;
    endtask

    // Start the programmed run; optional stop after N transfers, optional
    // table write attempt at a given cycle index while busy.
    task automatic run(input int bound, input int stop_after, input int we_at);
        bit stop_sent;
        stop_sent = 0;
        r = 0;
        done_r = -1;
        busy_done = -1;
        hold_bad = 0;
        xq_c.delete();
        xq_r.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        req_r0  = int'(t_kp_req);
        busy_r0 = int'(busy);
        for (int i = 1; i <= bound; i++) begin
            if (stop_after >= 0 && !stop_sent && xq_c.size() == stop_after && t_kp_req) begin
                stop = 1'b1;
                stop_sent = 1;
            end
            if (i == we_at) begin
                cfg_addr = '0;
                cfg_ctrl = 3'd7;
                cfg_rep  = 8'd7;
                cfg_we   = 1'b1;
            end
            step();
            r = i;
            stop   = 1'b0;
            cfg_we = 1'b0;
            if (done) begin
                done_r    = i;
                busy_done = int'(busy);
                break;
            end
        end
    endtask

    task automatic chk_xfers(input string tag);
        int got;
        check({tag, "_count"}, xq_c.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < xq_c.size()) ? xq_c[k] : -1;
            check($sformatf("%s_x%0d", tag, k), got, exp_q[k]);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_ctrl = '0;
        cfg_rep  = '0;
        cfg_len  = '0;
        cfg_loop = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        t_kp_ack = 1'b1;
        ack_mode = 0;
        cyc = 0;
        r = 0;
        step();
        step();
        check("rst_req",  int'(t_kp_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err",  int'(err), 0);
        check("rst_kctrl", int'(k_ctrl), 0);
        reset_n = 1'b1;
        step();

        // Two-entry program, ack tied high: 2,2,2,5 back to back.
        wr(0, 2, 3);
        wr(1, 5, 1);
        cfg_len  = 4'd2;
        cfg_loop = 1'b0;
        run(20, -1, -1);
        check("t1_fetch_req", req_r0, 0);
        check("t1_fetch_busy", busy_r0, 1);
        exp_q = {2, 2, 2, 5};
        chk_xfers("t1");
        check("t1_first_cyc", (xq_r.size() > 0) ? xq_r[0] : -1, 1);
        check("t1_last_cyc", (xq_r.size() > 3) ? xq_r[3] : -1, 4);
        check("t1_done_cyc", done_r, 5);
        check("t1_busy_at_done", busy_done, 0);

        // Same program, ack only every other cycle.
        ack_mode = 1;
        run(40, -1, -1);
        exp_q = {2, 2, 2, 5};
        chk_xfers("t2");
        check("t2_hold", hold_bad, 0);
        check("t2_done_seen", int'(done_r > 0), 1);
        ack_mode = 0;
        step();

        // Zero-rep entries around a real one.
        wr(0, 1, 0);
        wr(1, 3, 2);
        wr(2, 4, 0);
        cfg_len = 4'd3;
        run(20, -1, -1);
        exp_q = {3, 3};
        chk_xfers("t3");
        check("t3_first_cyc", (xq_r.size() > 0) ? xq_r[0] : -1, 2);
        check("t3_done_cyc", done_r, 5);

        // Looping single entry, stop after five transfers.
        wr(0, 6, 2);
        cfg_len  = 4'd1;
        cfg_loop = 1'b1;
        run(40, 5, -1);
        exp_q = {6, 6, 6, 6, 6, 6};
        chk_xfers("t4");
        check("t4_done_cyc", done_r, 7);
        check("t4_hold", hold_bad, 0);
        cfg_loop = 1'b0;
        step();

        // Illegal lengths.
        cfg_len = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_len0_err", int'(err), 1);
        check("t5_len0_busy", int'(busy), 0);
        check("t5_len0_req", int'(t_kp_req), 0);
        step();
        check("t5_len0_err_pulse", int'(err), 0);
        cfg_len = 4'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_len9_err", int'(err), 1);
        check("t5_len9_busy", int'(busy), 0);
        step();
        check("t5_len9_idle_req", int'(t_kp_req), 0);

        // Table write while busy must be ignored.
        wr(0, 2, 3);
        wr(1, 5, 1);
        cfg_len = 4'd2;
        run(20, -1, 2);
        exp_q = {2, 2, 2, 5};
        chk_xfers("t5_wbusy");
        run(20, -1, -1);
        exp_q = {2, 2, 2, 5};
        chk_xfers("t5_rerun");

        // Reset in the middle of ISSUE.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("t6_pre_req", int'(t_kp_req), 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("t6_rst_req", int'(t_kp_req), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        step();
        run(20, -1, -1);
        exp_q = {2, 2, 2, 5};
        chk_xfers("t6");
        check("t6_first_cyc", (xq_r.size() > 0) ? xq_r[0] : -1, 1);
        check("t6_done_cyc", done_r, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
